// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle controller.
// Holds the RV32 base opcodes, the controller state codes, the registered
// instruction-class encoding, the pc_sel / wb_sel encodings and the opcode
// classifier used in DECODE.
package rv_pkg;

  // Base opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Controller states (visible on the debug port)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  // pc_sel encodings
  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;

  // wb_sel encodings
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // Instruction class captured in DECODE
  typedef enum logic [3:0] {
    CLS_LOAD   = 4'd0,
    CLS_STORE  = 4'd1,
    CLS_OP     = 4'd2,
    CLS_OP_IMM = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } cls_e;

  typedef struct packed {
    logic legal;
    cls_e cls;
  } dec_t;

  function automatic dec_t decode_opcode(input logic [6:0] op);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = CLS_OP;
    case (op)
      OPC_LOAD:   d.cls = CLS_LOAD;
      OPC_STORE:  d.cls = CLS_STORE;
      OPC_OP:     d.cls = CLS_OP;
      OPC_OP_IMM: d.cls = CLS_OP_IMM;
      OPC_BRANCH: d.cls = CLS_BRANCH;
      OPC_JAL:    d.cls = CLS_JAL;
      OPC_JALR:   d.cls = CLS_JALR;
      OPC_LUI:    d.cls = CLS_LUI;
      OPC_AUIPC:  d.cls = CLS_AUIPC;
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_ctrl_instret_cnt.sv
// Retired-instruction counter: 32-bit, enabled, wraps FFFFFFFF -> 0.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset (count -> 0)
//   en_i    - increment by one this cycle
//   count_o - current count
module instret_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign cnt_d = en_i ? (cnt_q + 32'd1) : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32 control FSM.
// Sequences fetch / decode / execute / memory / write-back and raises a
// sticky trap on an unknown opcode. Only storage: state and instruction class
// (plus the instret counter sub-module).
// Ports:
//   clk, rst (async, active-low)
//   opcode, branch_taken          - datapath inputs
//   imem_req/imem_ack             - instruction fetch handshake
//   dmem_req/dmem_we/dmem_ack     - data access handshake
//   ir_we, pc_we, pc_sel, rf_we, wb_sel - datapath controls
//   state, illegal, instret       - debug / status
//
// state  | meaning
// FETCH  | imem_req held until imem_ack; ir_we on the ack cycle
// DECODE | classify opcode, register class (unknown -> TRAP)
// EXEC   | branches resolve here; LOAD/STORE -> MEM, others -> WB
// MEM    | dmem_req held until dmem_ack; STORE retires on the ack
// WB     | rf_we + pc_we, one cycle
// TRAP   | absorbing until reset, illegal = 1, everything idle
module mc_ctrl
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  logic [2:0] state_q, state_d;
  cls_e       cls_q, cls_d;
  dec_t       dec;

  logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, rf_we_c, illegal_c;
  logic [1:0] pc_sel_c, wb_sel_c;

  assign dec = decode_opcode(opcode);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    illegal_c  = 1'b0;
    pc_sel_c   = PC_SEL_PLUS4;
    wb_sel_c   = WB_SEL_ALU;
    case (state_q)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.legal) begin
          cls_d   = dec.cls;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            pc_we_c  = 1'b1;
            pc_sel_c = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
            state_d  = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls_q == CLS_STORE);
        if (dmem_ack) begin
          if (cls_q == CLS_STORE) begin
            pc_we_c = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = ST_FETCH;
        case (cls_q)
          CLS_JAL: begin
            pc_sel_c = PC_SEL_IMM;
            wb_sel_c = WB_SEL_PC4;
          end
          CLS_JALR: begin
            pc_sel_c = PC_SEL_JALR;
            wb_sel_c = WB_SEL_PC4;
          end
          CLS_LOAD: wb_sel_c = WB_SEL_MEM;
          default: ;
        endcase
      end
      ST_TRAP: illegal_c = 1'b1;
      default: state_d = ST_TRAP;  // unused codes 6/7
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_OP;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Reset must silence every output immediately, even though FETCH would
  // otherwise present imem_req combinationally.
  assign imem_req = imem_req_c & rst;
  assign dmem_req = dmem_req_c & rst;
  assign dmem_we  = dmem_we_c  & rst;
  assign ir_we    = ir_we_c    & rst;
  assign pc_we    = pc_we_c    & rst;
  assign rf_we    = rf_we_c    & rst;
  assign illegal  = illegal_c  & rst;
  assign pc_sel   = rst ? pc_sel_c : PC_SEL_PLUS4;
  assign wb_sel   = rst ? wb_sel_c : WB_SEL_ALU;
  assign state    = state_q;

  instret_cnt u_instret (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (pc_we),
    .count_o (instret)
  );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus a randomized
// instruction stream compared against a per-instruction behavioural model.
module tb_mc_ctrl;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_instret = '0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .state(state), .illegal(illegal), .instret(instret)
  );

  typedef struct {
    int cyc; int nir; int ir_cyc; int npc; int pc_cyc; int nrf; int rf_cyc;
    int ndreq; int ndwe; int excl;
    logic [1:0] pcs; logic [1:0] wbs;
  } obs_t;

  typedef struct {
    int cyc; int pc_cyc; int nrf; int ndreq; int ndwe;
    logic [1:0] pcs; logic [1:0] wbs;
  } exp_t;

  logic [6:0] legal_ops [9] = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
                               OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};

  // Expected outcome of one instruction from the ISA-level timing rules.
  function automatic exp_t model(input logic [6:0] op, input logic tk, input int wi, input int wd);
    exp_t e;
    bit mem = (op == OPC_LOAD) || (op == OPC_STORE);
    int base = (op == OPC_LOAD) ? 5 : (op == OPC_BRANCH) ? 3 : 4;
    e.cyc    = base + wi + (mem ? wd : 0);
    e.pc_cyc = e.cyc - 1;
    e.pcs    = (op == OPC_JAL) ? 2'b01 : (op == OPC_JALR) ? 2'b10 :
               (op == OPC_BRANCH && tk) ? 2'b01 : 2'b00;
    e.nrf    = (op == OPC_STORE || op == OPC_BRANCH) ? 0 : 1;
    e.wbs    = (op == OPC_JAL || op == OPC_JALR) ? 2'b10 : (op == OPC_LOAD) ? 2'b01 : 2'b00;
    e.ndreq  = mem ? wd + 1 : 0;
    e.ndwe   = (op == OPC_STORE) ? wd + 1 : 0;
    return e;
  endfunction

  // Drives one instruction (entered at posedge+1 in FETCH) and records what
  // the DUT did each cycle until its pc_we pulse, bounded to 40 cycles.
  task automatic run_instr(input logic [6:0] op, input logic tk, input int wi, input int wd,
                           output obs_t o);
    int icnt = 0, dcnt = 0, n = 0;
    bit done = 0;
    o = '{default: 0};
    while (!done && n < 40) begin
      opcode       = (state == ST_FETCH) ? 7'($urandom) : op;
      branch_taken = (state == ST_EXEC) ? tk : 1'($urandom);
      if (imem_req) begin imem_ack = (icnt == wi); icnt++; end
      else imem_ack = 1'($urandom);
      if (dmem_req) begin dmem_ack = (dcnt == wd); dcnt++; end
      else dmem_ack = 1'($urandom);
      #4;
      if (imem_req && dmem_req) o.excl++;
      if (ir_we) begin o.nir++; o.ir_cyc = n; end
      if (rf_we) begin o.nrf++; o.rf_cyc = n; o.wbs = wb_sel; end
      if (dmem_req) begin o.ndreq++; if (dmem_we) o.ndwe++; end
      if (pc_we) begin o.npc++; o.pc_cyc = n; o.pcs = pc_sel; done = 1; end
      n++;
      @(posedge clk); #1;
    end
    o.cyc = n;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (state !== ST_FETCH) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_total++; if ({imem_req, dmem_req, ir_we, pc_we, rf_we, illegal} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {imem_req, dmem_req, ir_we, pc_we, rf_we, illegal});
    else n_pass++;
    n_total++; if ({pc_sel, wb_sel} !== 4'b0) $display("FAIL reset_sel: got %b want 0000", {pc_sel, wb_sel}); else n_pass++;
    n_total++; if (instret !== 32'd0) $display("FAIL reset_instret: got %h want 0", instret); else n_pass++;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b1) $display("FAIL reset_release_imem_req: got %b want 1", imem_req); else n_pass++;
    exp_instret = '0;
  endtask

  task automatic test_addi();
    obs_t o;
    run_instr(OPC_OP_IMM, 1'b0, 0, 0, o);
    exp_instret++;
    n_total++; if (o.ir_cyc !== 0 || o.nir !== 1) $display("FAIL addi_ir_we: cycle %0d count %0d want cycle 0 count 1", o.ir_cyc, o.nir); else n_pass++;
    n_total++; if (o.pc_cyc !== 3 || o.rf_cyc !== 3) $display("FAIL addi_wb_cycle: pc %0d rf %0d want 3", o.pc_cyc, o.rf_cyc); else n_pass++;
    n_total++; if (o.pcs !== 2'b00 || o.wbs !== 2'b00) $display("FAIL addi_sel: pc_sel %b wb_sel %b want 00 00", o.pcs, o.wbs); else n_pass++;
    n_total++; if (instret !== exp_instret) $display("FAIL addi_instret: got %h want %h", instret, exp_instret); else n_pass++;
  endtask

  task automatic test_branch();
    obs_t o;
    for (int t = 1; t >= 0; t--) begin
      run_instr(OPC_BRANCH, 1'(t), 0, 0, o);
      exp_instret++;
      n_total++; if (o.pc_cyc !== 2 || o.npc !== 1) $display("FAIL beq%0d_pc_we: cycle %0d count %0d want 2 1", t, o.pc_cyc, o.npc); else n_pass++;
      n_total++; if (o.pcs !== (t ? 2'b01 : 2'b00)) $display("FAIL beq%0d_pc_sel: got %b want %b", t, o.pcs, (t ? 2'b01 : 2'b00)); else n_pass++;
      n_total++; if (o.nrf !== 0) $display("FAIL beq%0d_rf_we: got %0d want 0", t, o.nrf); else n_pass++;
    end
    n_total++; if (instret !== exp_instret) $display("FAIL beq_instret: got %h want %h", instret, exp_instret); else n_pass++;
  endtask

  task automatic test_load_wait();
    obs_t o;
    run_instr(OPC_LOAD, 1'b0, 0, 3, o);
    exp_instret++;
    n_total++; if (o.ndreq !== 4 || o.ndwe !== 0) $display("FAIL lw_dmem: req %0d we %0d want 4 0", o.ndreq, o.ndwe); else n_pass++;
    n_total++; if (o.nrf !== 1 || o.wbs !== 2'b01) $display("FAIL lw_wb: rf %0d wb_sel %b want 1 01", o.nrf, o.wbs); else n_pass++;
    n_total++; if (o.cyc !== 8) $display("FAIL lw_cycles: got %0d want 8", o.cyc); else n_pass++;
  endtask

  task automatic test_store_jalr();
    obs_t o;
    run_instr(OPC_STORE, 1'b0, 0, 0, o);
    exp_instret++;
    n_total++; if (o.ndwe !== 1 || o.ndreq !== 1) $display("FAIL sw_dmem_we: we %0d req %0d want 1 1", o.ndwe, o.ndreq); else n_pass++;
    n_total++; if (o.pc_cyc !== 3 || o.nrf !== 0) $display("FAIL sw_pc_rf: pc cycle %0d rf %0d want 3 0", o.pc_cyc, o.nrf); else n_pass++;
    run_instr(OPC_JALR, 1'b0, 0, 0, o);
    exp_instret++;
    n_total++; if (o.pcs !== 2'b10 || o.wbs !== 2'b10 || o.nrf !== 1) $display("FAIL jalr_wb: pc_sel %b wb_sel %b rf %0d want 10 10 1", o.pcs, o.wbs, o.nrf); else n_pass++;
    n_total++; if (instret !== exp_instret) $display("FAIL sw_jalr_instret: got %h want %h", instret, exp_instret); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [6:0] op;
    logic tk;
    int wi, wd;
    for (int k = 0; k < 30; k++) begin
      op = legal_ops[$urandom_range(0, 8)];
      tk = 1'($urandom);
      wi = $urandom_range(0, 3);
      wd = $urandom_range(0, 3);
      e  = model(op, tk, wi, wd);
      run_instr(op, tk, wi, wd, o);
      exp_instret++;
      n_total++; if (o.cyc !== e.cyc || o.pc_cyc !== e.pc_cyc || o.npc !== 1)
        $display("FAIL rand%0d_timing op %b: cyc %0d pc_cyc %0d npc %0d want %0d %0d 1", k, op, o.cyc, o.pc_cyc, o.npc, e.cyc, e.pc_cyc);
      else n_pass++;
      n_total++; if (o.pcs !== e.pcs) $display("FAIL rand%0d_pc_sel op %b: got %b want %b", k, op, o.pcs, e.pcs); else n_pass++;
      n_total++; if (o.nrf !== e.nrf || (e.nrf == 1 && o.wbs !== e.wbs))
        $display("FAIL rand%0d_wb op %b: rf %0d wb_sel %b want %0d %b", k, op, o.nrf, o.wbs, e.nrf, e.wbs);
      else n_pass++;
      n_total++; if (o.ndreq !== e.ndreq || o.ndwe !== e.ndwe)
        $display("FAIL rand%0d_dmem op %b: req %0d we %0d want %0d %0d", k, op, o.ndreq, o.ndwe, e.ndreq, e.ndwe);
      else n_pass++;
      n_total++; if (o.nir !== 1 || o.ir_cyc !== wi || o.excl !== 0)
        $display("FAIL rand%0d_fetch: ir %0d at %0d excl %0d want 1 at %0d excl 0", k, o.nir, o.ir_cyc, o.excl, wi);
      else n_pass++;
      n_total++; if (instret !== exp_instret) $display("FAIL rand%0d_instret: got %h want %h", k, instret, exp_instret); else n_pass++;
    end
  endtask

  task automatic test_trap();
    opcode = OPC_LOAD; imem_ack = 1'b1;
    @(posedge clk); #1;
    opcode = 7'b1111111;
    @(posedge clk); #1;
    n_total++; if (state !== ST_TRAP || illegal !== 1'b1) $display("FAIL trap_entry: state %0d illegal %b want 5 1", state, illegal); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'(i);
      dmem_ack = 1'($urandom);
      opcode   = 7'($urandom);
      #4;
      n_total++;
      if (state !== ST_TRAP || illegal !== 1'b1 || {imem_req, dmem_req, ir_we, pc_we, rf_we} !== 5'b0)
        $display("FAIL trap_hold%0d: state %0d illegal %b outs %b want 5 1 00000", i, state, illegal, {imem_req, dmem_req, ir_we, pc_we, rf_we});
      else n_pass++;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    n_total++; if (instret !== exp_instret) $display("FAIL trap_instret: got %h want %h", instret, exp_instret); else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    obs_t o;
    rst = 1'b0; #2; rst = 1'b1;
    exp_instret = '0;
    @(posedge clk); #1;
    n_total++; if (illegal !== 1'b0 || state !== ST_FETCH) $display("FAIL trap_cleared: illegal %b state %0d want 0 0", illegal, state); else n_pass++;
    run_instr(OPC_OP, 1'b0, 1, 0, o); exp_instret++;
    run_instr(OPC_LUI, 1'b0, 0, 0, o); exp_instret++;
    n_total++; if (instret !== exp_instret) $display("FAIL pre_mem_instret: got %h want %h", instret, exp_instret); else n_pass++;
    opcode = OPC_LOAD; imem_ack = 1'b1;
    @(posedge clk); #1; imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++; if (dmem_req !== 1'b1 || state !== ST_MEM) $display("FAIL mem_reached: dmem_req %b state %0d want 1 3", dmem_req, state); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (dmem_req !== 1'b0 || state !== ST_FETCH || instret !== 32'd0)
      $display("FAIL mid_mem_reset: dmem_req %b state %0d instret %h want 0 0 0", dmem_req, state, instret);
    else n_pass++;
    #1 rst = 1'b1;
    exp_instret = '0;
    @(posedge clk); #1;
    n_total++; if (state !== ST_FETCH || imem_req !== 1'b1) $display("FAIL post_reset_fetch: state %0d imem_req %b want 0 1", state, imem_req); else n_pass++;
    force dut.u_instret.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_instret.cnt_q;
    exp_instret = 32'hFFFF_FFFF;
    n_total++; if (instret !== exp_instret) $display("FAIL instret_preload: got %h want %h", instret, exp_instret); else n_pass++;
    run_instr(OPC_OP_IMM, 1'b0, 0, 0, o);
    exp_instret++;
    n_total++; if (instret !== exp_instret) $display("FAIL instret_wrap: got %h want %h", instret, exp_instret); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_load_wait();
    test_store_jalr();
    test_random();
    test_trap();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
